async_fifo_wptr_full: RTL
=========================

# async_fifo_wptr_full

Write-domain pointer and full-flag controller for the async FIFO. It accepts write requests and produces the write address and memory write enable. It drives a registered Gray-coded write pointer that crosses into the read domain through the flop synchronizers. It derives `full` and `almost_full` from the read pointer after that pointer has been synchronized back into the write domain.

## Interface
Parameters:
- `ADDR_WIDTH`, default 4: FIFO address width; depth is `DEPTH = 2**ADDR_WIDTH`; pointers are `ADDR_WIDTH+1` bits.
- `AF_MARGIN`, default 2: `almost_full` asserts when occupancy ≥ `DEPTH - AF_MARGIN`; legal range 1..DEPTH-1.

Ports:
- `clk`  in  1  write-domain clock; the block uses one clock only.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `wr_en`  in  1  write request for the current cycle.
- `rd_ptr_gray_sync`  in  ADDR_WIDTH+1  read pointer, Gray-coded, already synchronized into `clk`.
- `mem_we`  out  1  memory write enable; combinational, `wr_en & ~full`.
- `wr_addr`  out  ADDR_WIDTH  memory write address; the low bits of the binary write pointer.
- `wr_ptr_gray`  out  ADDR_WIDTH+1  registered Gray write pointer sent to the read-domain synchronizer.
- `full`  out  1  registered full flag.
- `almost_full`  out  1  registered almost-full flag.
- `overflow`  out  1  sticky error flag: a write was attempted while `full`.

## Operation
- State registers: binary pointer `wbin` (ADDR_WIDTH+1), `wr_ptr_gray`, `full`, `almost_full`, `overflow`.
- A write is accepted when `wr_en=1` and `full=0`. On acceptance:
  - `wbin_next = wbin + 1`, wrapping modulo `2**(ADDR_WIDTH+1)`.
  - `wgray_next = wbin_next ^ (wbin_next >> 1)`.
- Without an accepted write, `wbin_next = wbin`.
- Full condition, evaluated on the next pointer: `full_next = (wgray_next == {~rd_ptr_gray_sync[MSB:MSB-1], rd_ptr_gray_sync[MSB-2:0]})`.
- Occupancy:
  - Convert `rd_ptr_gray_sync` to binary `rbin` with a prefix XOR from the MSB down.
  - `occ_next = wbin_next - rbin`, computed in ADDR_WIDTH+1 bits, unsigned, wrapping.
  - `almost_full_next = (occ_next >= DEPTH - AF_MARGIN)`.
- Write while full (`wr_en=1`, `full=1`):
  - The write is dropped: `mem_we=0` and the pointer holds.
  - `overflow` sets on the next edge and stays set until reset.
- Deassertion of `full` and `almost_full` is pessimistic. They clear only after the read pointer advance has passed through the synchronizer, which takes 2–3 `clk` cycles.
- Reset, asynchronous and possibly mid-operation: `wbin`, `wr_ptr_gray`, `wr_addr`, `full`, `almost_full` and `overflow` all go to 0 immediately. `mem_we` follows `wr_en` while in reset, because `full=0`.

## Timing
- `mem_we` and `wr_addr` are valid in the same cycle as `wr_en`. The memory captures the data on that `clk` edge.
- `wr_ptr_gray`, `full` and `almost_full` update on the same edge as the accepted write. There is 1 cycle of latency from acceptance to the new flag values.
- `wr_ptr_gray` changes at most one bit per `clk` edge and is driven directly from a flop, with no logic between the flop and the output. This is mandatory for CDC safety.
- If a write is accepted in the same cycle that `rd_ptr_gray_sync` advances, both take effect in that cycle's `full_next` and `occ_next`.
- Pointer wrap (`wbin` from all-ones to 0) is glitch-free. The MSB toggles, marking the next lap.

## Configuration
- Macro: `ASYNC_FIFO_ALMOST_FULL_EN`.
- Defined: the `rbin` conversion, the occupancy subtractor and the `almost_full` register are compiled in as described above.
- Undefined: that logic is omitted and `almost_full` is tied to 0. `full` behaviour is unchanged.

## Test plan
(Defaults: ADDR_WIDTH=4, DEPTH=16, AF_MARGIN=2.)
- Reset: assert `reset_n=0` mid-stream with `wbin=7` → all registered outputs are 0 in the same cycle; after release, `wr_addr=0`.
- Fill: `rd_ptr_gray_sync=0`, 16 consecutive writes →
  - `almost_full=1` after the 14th write;
  - `full=1` after the 16th write, with `wr_ptr_gray=5'b11000` (binary 16);
  - `mem_we` high for exactly 16 cycles.
- Overflow: with `full=1`, pulse `wr_en` once → `mem_we=0`, pointer unchanged, `overflow=1` from the next cycle and still 1 after 10 more cycles.
- Drain and wrap: from full, step `rd_ptr_gray_sync` to Gray(1) → `full=0` on the next edge. Write once more → `full=1`, `wbin=17`, `wr_addr=1`.
- Gray integrity: run 100 random writes with a randomly advancing legal `rd_ptr_gray_sync` → every `wr_ptr_gray` transition has Hamming distance ≤ 1, and occupancy never exceeds 16.
- Macro off: rerun the fill test without `ASYNC_FIFO_ALMOST_FULL_EN` → `almost_full` stays 0 throughout, and `full` timing is identical to the fill test.

Source files
------------

// File: rtl/async_fifo_wptr_full.sv
// Write-side pointer and full-flag controller for the async FIFO.
// Tracks the binary write pointer, publishes a registered Gray copy for the
// read-domain synchronizer, and flags full/almost-full against the read
// pointer that has already been synchronized back into this clock domain.
// Optional feature macro: ASYNC_FIFO_ALMOST_FULL_EN compiles in the occupancy
// subtractor and almost_full register. When it is undefined, almost_full is
// tied low and full behaves the same.
module async_fifo_wptr_full #(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_MARGIN  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rd_ptr_gray_sync,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Full means the write pointer is exactly one lap ahead of the read
    // pointer. In Gray code that is the read pointer with its top two bits
    // inverted. Building the mask this way also works when ADDR_WIDTH is 1.
    localparam logic [PTR_W-1:0] FULL_FLIP = PTR_W'(3) << (ADDR_WIDTH - 1);

    if (AF_MARGIN < 1 || AF_MARGIN > DEPTH - 1) begin : g_bad_af_margin
        $error("async_fifo_wptr_full: AF_MARGIN must lie in 1..DEPTH-1");
    end

    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] wbin_next;
    logic [PTR_W-1:0] wgray_next;
    logic [PTR_W-1:0] rd_full_pattern;
    logic             wr_accept;
    logic             full_next;

    // A write is dropped while full. mem_we must never qualify a write that
    // the pointer does not also count.
    assign wr_accept = wr_en & ~full;
    assign mem_we    = wr_accept;
    assign wr_addr   = wbin[ADDR_WIDTH-1:0];

    // The pointer wraps naturally modulo 2**PTR_W. The MSB toggles once per lap.
    assign wbin_next       = wbin + PTR_W'(wr_accept);
    assign wgray_next      = wbin_next ^ (wbin_next >> 1);
    assign rd_full_pattern = rd_ptr_gray_sync ^ FULL_FLIP;
    assign full_next       = (wgray_next == rd_full_pattern);

    // Pointer state. wr_ptr_gray comes straight from a flop so the read
    // domain only ever samples a single-bit change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wbin        <= '0;
            wr_ptr_gray <= '0;
        end else begin
            wbin        <= wbin_next;
            wr_ptr_gray <= wgray_next;
        end
    end

    // Full flag. It is evaluated on the next pointer, so it rises on the same
    // edge that accepts the final write. It falls only once a read advance has
    // come through the synchronizer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full <= 1'b0;
        end else begin
            full <= full_next;
        end
    end

    // Sticky overflow. A write attempted while full sets it, and only reset
    // clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end
    end

`ifdef ASYNC_FIFO_ALMOST_FULL_EN
    localparam logic [PTR_W-1:0] AF_THRESH = PTR_W'(DEPTH - AF_MARGIN);

    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] occ_next;
    logic             almost_full_next;

    // Gray to binary conversion. Bit i of the result is the XOR of every
    // Gray bit at position i and above.
    always_comb begin
        rbin = '0;
        for (int i = 0; i < PTR_W; i++) begin
            rbin[i] = ^(rd_ptr_gray_sync >> i);
        end
    end

    // Occupancy uses wrapping unsigned arithmetic. It is correct across the lap
    // boundary because occupancy never exceeds DEPTH.
    assign occ_next         = wbin_next - rbin;
    assign almost_full_next = (occ_next >= AF_THRESH);

    // Almost-full flag. It registers on the same edge as full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= almost_full_next;
        end
    end
`else
    assign almost_full = 1'b0;
`endif

endmodule
